mac_pipe: RTL
=============

Name: mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate engine; successor to the 8x8 -> 16-bit MAC.
- Accepts one operand pair per clock under a valid qualifier and accumulates products over frames of FRAME_LEN samples.
- At each frame end it emits the frame result with a one-cycle valid pulse, then restarts accumulation from zero.
- Sits between a sample source (filter tap / vector feeder) and a result consumer that cannot apply backpressure.

Parameters:
- AW, 8: operand width in bits (opa, opb).
- ACCW, 24: accumulator and result width; must satisfy ACCW >= 2*AW.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and accumulator.
- FRAME_LEN, 16: valid samples per frame; range 1..65535.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  synchronous active-high reset; clears all state.
- in_valid  in  1  opa/opb carry a sample this cycle.
- opa  in  AW  operand A.
- opb  in  AW  operand B.
- acc  out  ACCW  running accumulator (registered).
- out_valid  out  1  one-cycle pulse: out_data holds a completed frame result.
- out_data  out  ACCW  frame result; holds its value until the next frame result.
- ovf  out  1  overflow (or saturation) occurred in the frame just reported; valid with out_valid, held until the next frame result.
- cnt  out  16  samples accumulated so far in the current frame.

Behaviour:
- Reset:
  - clr=1 at a rising edge zeroes stage valids, operand and product registers, acc, cnt, out_data, out_valid and ovf, plus the internal sticky-overflow flag.
  - clr dominates in_valid on the same edge.
  - clr mid-frame discards the partial frame; in-flight samples are lost and produce no out_valid.
- Pipeline, with edge E the edge sampling in_valid=1:
  - S1 at E: opa/opb registered.
  - S2 at E+1: product registered, 2*AW bits; signed multiply when SIGNED=1.
  - S3 at E+2: acc and cnt updated.
  - Sample-to-acc latency is 2 cycles after the sampling edge.
  - Full throughput: one sample per cycle, no stalls. Bubbles (in_valid=0) propagate and leave acc/cnt unchanged.
- Width rule: product is extended to ACCW bits (sign-extended if SIGNED=1, else zero-extended) and added to acc at ACCW bits.
- Overflow detection:
  - Unsigned: carry out of bit ACCW-1.
  - Signed: both operands' signs equal and the result sign differs.
  - On overflow the internal sticky flag is set for the rest of the frame.
- Frame end: when an S3 update occurs with cnt == FRAME_LEN-1, on the same edge:
  - out_data <= the final sum, including this sample, after the overflow rule below.
  - out_valid <= 1 for exactly one cycle.
  - ovf <= sticky | this-sample overflow.
  - acc <= 0, cnt <= 0, sticky <= 0.
- Next-frame samples may follow back-to-back; the first sample after frame end accumulates onto zero on the following edge.
- FRAME_LEN=1: every valid sample produces out_valid, with out_data equal to the extended product.
- out_valid is 0 on every cycle without a frame-end update.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: on overflow, the sum clamps to the limit in the overflow direction instead of wrapping, and stays clamped until further products move it back in range.
  - Unsigned limit: 2^ACCW-1.
  - Signed limits: 2^(ACCW-1)-1 on positive overflow, -2^(ACCW-1) on negative overflow.
  - ovf reports that saturation occurred.
- Undefined: the sum wraps modulo 2^ACCW; ovf reports that a wrap occurred. No clamp logic is synthesised.

Test Plan:
- Frame result: AW=8, ACCW=24, FRAME_LEN=10, SIGNED=0; clr for 2 cycles, then opa=1..10 with opb=10 on consecutive cycles -> acc steps 10,30,60,...; single out_valid pulse 2 cycles after the 10th sample edge; out_data=550, ovf=0, then acc=0 and cnt=0.
- Bubbles: same stimulus with in_valid=0 on every other cycle -> out_data=550; out_valid occurs 2 cycles after the 10th valid sample; acc is unchanged during bubbles.
- Overflow: ACCW=16, FRAME_LEN=2, opa=opb=255 twice -> out_data=64514 (wrap) with MAC_SAT_EN undefined, or 65535 with it defined; ovf=1 in both builds. The next frame of 1*1, 1*1 gives out_data=2, ovf=0.
- Signed: SIGNED=1, AW=8, ACCW=24, FRAME_LEN=3; samples (-128,127), (-1,-1), (5,-3) -> out_data = -16270 (0xFFC072), ovf=0.
- Reset mid-frame: 4 samples of a FRAME_LEN=10 frame, then clr=1 for 1 cycle, then 10 samples of 2*3 -> no out_valid before clr, no out_valid from the discarded samples, then out_data=60.
- Back-to-back frames: FRAME_LEN=4, 12 continuous samples of 1*1 -> out_valid pulses exactly 4 cycles apart, each with out_data=4.

Source files
------------

// File: rtl/mac_pipe.sv
// -----------------------------------------------------------------------------
// mac_pipe -- parametrised three-stage pipelined multiply-accumulate engine.
//
// Accepts one operand pair per clock under in_valid and accumulates the
// products over frames of FRAME_LEN valid samples. At each frame end the
// result is published on out_data with a one-cycle out_valid pulse and the
// accumulator restarts from zero. There is no backpressure.
//
// Pipeline (edge E samples in_valid=1):
//   S1 @E   : operands registered
//   S2 @E+1 : 2*AW-bit product registered (signed multiply when SIGNED=1)
//   S3 @E+2 : acc / cnt updated, frame end detected
//
// Parameters:
//   AW        operand width
//   ACCW      accumulator / result width (ACCW >= 2*AW)
//   SIGNED    0 = unsigned, 1 = two's-complement operands and accumulator
//   FRAME_LEN valid samples per frame, 1..65535
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high clear of all state
//   in_valid   opa/opb carry a sample this cycle
//   opa, opb   operands (AW bits)
//   acc        running accumulator (registered, ACCW bits)
//   out_valid  one-cycle pulse: out_data holds a completed frame result
//   out_data   frame result, held until the next frame result
//   ovf        overflow/saturation in the reported frame, held with out_data
//   cnt        samples accumulated so far in the current frame
//
// Build option:
//   MAC_SAT_EN  when defined the sum clamps to the limit in the overflow
//               direction; otherwise it wraps modulo 2^ACCW.
// -----------------------------------------------------------------------------
module mac_pipe #(
    parameter int AW        = 8,
    parameter int ACCW      = 24,
    parameter int SIGNED    = 0,
    parameter int FRAME_LEN = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [AW-1:0]   opa,
    input  logic [AW-1:0]   opb,
    output logic [ACCW-1:0] acc,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    output logic            ovf,
    output logic [15:0]     cnt
);

    localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

    // Pipeline registers
    logic              r_s1_valid;
    logic [AW-1:0]     r_opa;
    logic [AW-1:0]     r_opb;
    logic              r_s2_valid;
    logic [2*AW-1:0]   r_prod;

    // Accumulation / result registers
    logic [ACCW-1:0]   r_acc;
    logic [15:0]       r_cnt;
    logic              r_sticky;
    logic              r_out_valid;
    logic [ACCW-1:0]   r_out_data;
    logic              r_ovf;

    // Combinational datapath
    logic [2*AW-1:0]   w_prod;
    logic [ACCW-1:0]   w_prod_ext;
    logic [ACCW:0]     w_sum_full;
    logic [ACCW-1:0]   w_sum_wrap;
    logic [ACCW-1:0]   w_sum;
    logic              w_ovf;
    logic              w_frame_end;

    // Multiply and extend. Operands are widened to 2*AW before the multiply
    // so the full product is kept; the signed variant sign-extends first.
    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*AW-1:0] w_sa;
            logic signed [2*AW-1:0] w_sb;
            assign w_sa       = $signed({{AW{r_opa[AW-1]}}, r_opa});
            assign w_sb       = $signed({{AW{r_opb[AW-1]}}, r_opb});
            assign w_prod     = $unsigned(w_sa * w_sb);
            assign w_prod_ext = ACCW'($signed(r_prod));
            // Addends with equal signs producing a result of the other sign.
            assign w_ovf      = (r_acc[ACCW-1] == w_prod_ext[ACCW-1]) &&
                                (w_sum_wrap[ACCW-1] != r_acc[ACCW-1]);
        end else begin : g_unsigned
            assign w_prod     = {{AW{1'b0}}, r_opa} * {{AW{1'b0}}, r_opb};
            assign w_prod_ext = ACCW'(r_prod);
            assign w_ovf      = w_sum_full[ACCW];
        end
    endgenerate

    assign w_sum_full  = {1'b0, r_acc} + {1'b0, w_prod_ext};
    assign w_sum_wrap  = w_sum_full[ACCW-1:0];
    assign w_frame_end = r_s2_valid && (r_cnt == LAST_CNT);

    always_comb begin
        // NOTE: default assigned first so every path drives w_sum and no latch is inferred.
        w_sum = w_sum_wrap;
`ifdef MAC_SAT_EN
        // Clamp in the overflow direction; for signed data both addends share
        // the sign of r_acc when overflow occurs, so r_acc's sign picks the limit.
        if (w_ovf) begin
            if (SIGNED != 0) begin
                w_sum = r_acc[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}}
                                      : {1'b0, {(ACCW-1){1'b1}}};
            end else begin
                w_sum = '1;
            end
        end
`endif
    end

    // NOTE: reset is synchronous (clr sampled on the clock edge) and dominates in_valid.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_s1_valid  <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_s2_valid  <= 1'b0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every stage reads last cycle's values.
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_opa <= opa;
                r_opb <= opb;
            end

            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_prod <= w_prod;
            end

            r_out_valid <= 1'b0;
            if (r_s2_valid) begin
                if (w_frame_end) begin
                    r_out_data  <= w_sum;
                    r_out_valid <= 1'b1;
                    r_ovf       <= r_sticky | w_ovf;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_sticky    <= 1'b0;
                end else begin
                    r_acc       <= w_sum;
                    r_cnt       <= r_cnt + 16'd1;
                    r_sticky    <= r_sticky | w_ovf;
                end
            end
        end
    end

    assign acc       = r_acc;
    assign cnt       = r_cnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ovf       = r_ovf;

endmodule
